// File: rtl/layer_seq_ctrl.sv
// layer_seq_ctrl: sequences a stack of conv / depthwise layers over a feature map,
// cutting each layer's output into TILE_H x TILE_W tiles and handing them one at a
// time to a compute engine (run_start / run_done handshake). Feature maps
// ping-pong between two base addresses from layer to layer.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, abort        begin a run / abandon the current run
//   busy, done, err     status; err: 0 ok, 1 bad stride, 2 aborted, 3 zero dimension
//   tbl_*               layer table write port (accepted only while idle)
//   cfg_*               run configuration: layer count, input dims, FM base addresses
//   layer_idx ... cur_* current layer geometry
//   tile_*              current tile in output and input coordinates
//   in/out_base_addr    FM buffers for the current layer
//   run_start, run_done compute engine handshake
module layer_seq_ctrl #(
  parameter int unsigned DIM_W      = 16,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned MAX_LAYERS = 32,
  parameter int unsigned TILE_H     = 16,
  parameter int unsigned TILE_W     = 16,
  localparam int unsigned LW        = $clog2(MAX_LAYERS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              err,
  input  logic                    tbl_we,
  input  logic [LW-1:0]           tbl_waddr,
  input  logic                    tbl_mode,
  input  logic [1:0]              tbl_stride,
  input  logic [DIM_W-1:0]        tbl_out_c,
  input  logic [LW:0]             cfg_num_layers,
  input  logic [DIM_W-1:0]        cfg_in_h,
  input  logic [DIM_W-1:0]        cfg_in_w,
  input  logic [DIM_W-1:0]        cfg_in_c,
  input  logic [ADDR_W-1:0]       cfg_fm_base0,
  input  logic [ADDR_W-1:0]       cfg_fm_base1,
  output logic [LW-1:0]           layer_idx,
  output logic                    run_mode,
  output logic [DIM_W-1:0]        cur_in_h,
  output logic [DIM_W-1:0]        cur_in_w,
  output logic [DIM_W-1:0]        cur_in_c,
  output logic [DIM_W-1:0]        cur_out_h,
  output logic [DIM_W-1:0]        cur_out_w,
  output logic [DIM_W-1:0]        cur_out_c,
  output logic [DIM_W-1:0]        cur_stride,
  output logic [DIM_W-1:0]        tile_out_row,
  output logic [DIM_W-1:0]        tile_out_col,
  output logic [DIM_W-1:0]        tile_out_h,
  output logic [DIM_W-1:0]        tile_out_w,
  output logic signed [DIM_W:0]   tile_in_row,
  output logic signed [DIM_W:0]   tile_in_col,
  output logic [DIM_W-1:0]        tile_in_h,
  output logic [DIM_W-1:0]        tile_in_w,
  output logic [ADDR_W-1:0]       in_base_addr,
  output logic [ADDR_W-1:0]       out_base_addr,
  output logic                    run_start,
  input  logic                    run_done
);

  // Extended width so tile/row arithmetic never wraps.
  localparam int unsigned AW = DIM_W + 2;
  localparam int unsigned KERNEL = 3;

  localparam logic [1:0] ErrOk     = 2'd0;
  localparam logic [1:0] ErrStride = 2'd1;
  localparam logic [1:0] ErrAbort  = 2'd2;
  localparam logic [1:0] ErrZero   = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StCfg,
    StIssue,
    StWait,
    StNextLayer,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [LW-1:0]    layer_idx_q, layer_idx_d;
  logic             base_sel_q, base_sel_d;
  logic             abort_q, abort_d;
  logic [1:0]       err_q, err_d;
  logic             mode_q, mode_d;
  logic [1:0]       stride_q, stride_d;
  logic [DIM_W-1:0] in_h_q, in_h_d, in_w_q, in_w_d, in_c_q, in_c_d;
  logic [DIM_W-1:0] out_h_q, out_h_d, out_w_q, out_w_d, out_c_q, out_c_d;
  logic [DIM_W-1:0] row_q, row_d, col_q, col_d;

  // Layer table; contents survive reset.
  logic             tbl_mode_mem   [MAX_LAYERS];
  logic [1:0]       tbl_stride_mem [MAX_LAYERS];
  logic [DIM_W-1:0] tbl_out_c_mem  [MAX_LAYERS];

  always_ff @(posedge clk) begin
    if (tbl_we && (state_q == StIdle)) begin
      tbl_mode_mem[tbl_waddr]   <= tbl_mode;
      tbl_stride_mem[tbl_waddr] <= tbl_stride;
      tbl_out_c_mem[tbl_waddr]  <= tbl_out_c;
    end
  end

  logic             rd_mode;
  logic [1:0]       rd_stride;
  logic [DIM_W-1:0] rd_out_c;
  assign rd_mode   = tbl_mode_mem[layer_idx_q];
  assign rd_stride = tbl_stride_mem[layer_idx_q];
  assign rd_out_c  = tbl_out_c_mem[layer_idx_q];

  // Tile geometry, derived from the current row/col registers.
  logic [AW-1:0]    rem_h, rem_w, next_row, next_col;
  logic [DIM_W-1:0] t_oh, t_ow;
  logic             abort_pend;

  always_comb begin
    rem_h    = AW'(out_h_q) - AW'(row_q);
    rem_w    = AW'(out_w_q) - AW'(col_q);
    t_oh     = (rem_h < AW'(TILE_H)) ? rem_h[DIM_W-1:0] : DIM_W'(TILE_H);
    t_ow     = (rem_w < AW'(TILE_W)) ? rem_w[DIM_W-1:0] : DIM_W'(TILE_W);
    next_row = AW'(row_q) + AW'(TILE_H);
    next_col = AW'(col_q) + AW'(TILE_W);
  end

  // An abort seen this cycle acts immediately, not only once latched.
  assign abort_pend = abort_q | abort;

  always_comb begin
    state_d     = state_q;
    layer_idx_d = layer_idx_q;
    base_sel_d  = base_sel_q;
    abort_d     = abort_q;
    err_d       = err_q;
    mode_d      = mode_q;
    stride_d    = stride_q;
    in_h_d      = in_h_q;
    in_w_d      = in_w_q;
    in_c_d      = in_c_q;
    out_h_d     = out_h_q;
    out_w_d     = out_w_q;
    out_c_d     = out_c_q;
    row_d       = row_q;
    col_d       = col_q;

    if ((state_q != StIdle) && abort) begin
      abort_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          abort_d = 1'b0;
          if (cfg_num_layers == '0) begin
            err_d   = ErrZero;
            state_d = StDone;
          end else begin
            err_d       = ErrOk;
            in_h_d      = cfg_in_h;
            in_w_d      = cfg_in_w;
            in_c_d      = cfg_in_c;
            layer_idx_d = '0;
            base_sel_d  = 1'b0;
            state_d     = StCfg;
          end
        end
      end

      StCfg: begin
        mode_d   = rd_mode;
        stride_d = rd_stride;
        out_c_d  = rd_out_c;
        // ceil(x/2) for stride 2; the value is irrelevant for an illegal stride.
        out_h_d  = (rd_stride == 2'd2) ? DIM_W'((AW'(in_h_q) + AW'(1)) >> 1) : in_h_q;
        out_w_d  = (rd_stride == 2'd2) ? DIM_W'((AW'(in_w_q) + AW'(1)) >> 1) : in_w_q;
        row_d    = '0;
        col_d    = '0;
        if (abort_pend) begin
          err_d   = ErrAbort;
          state_d = StDone;
        end else if ((rd_stride != 2'd1) && (rd_stride != 2'd2)) begin
          err_d   = ErrStride;
          state_d = StDone;
        end else if ((in_h_q == '0) || (in_w_q == '0)) begin
          err_d   = ErrZero;
          state_d = StDone;
        end else begin
          state_d = StIssue;
        end
      end

      StIssue: begin
        if (abort_pend) begin
          err_d   = ErrAbort;
          state_d = StDone;
        end else begin
          state_d = StWait;
        end
      end

      StWait: begin
        if (run_done) begin
          if (abort_pend) begin
            err_d   = ErrAbort;
            state_d = StDone;
          end else if (next_col >= AW'(out_w_q)) begin
            col_d = '0;
            if (next_row >= AW'(out_h_q)) begin
              state_d = StNextLayer;
            end else begin
              row_d   = next_row[DIM_W-1:0];
              state_d = StIssue;
            end
          end else begin
            col_d   = next_col[DIM_W-1:0];
            state_d = StIssue;
          end
        end
      end

      StNextLayer: begin
        in_h_d     = out_h_q;
        in_w_d     = out_w_q;
        in_c_d     = out_c_q;
        base_sel_d = ~base_sel_q;
        if ((LW+1)'(layer_idx_q) == cfg_num_layers - (LW+1)'(1)) begin
          err_d   = abort_pend ? ErrAbort : ErrOk;
          state_d = StDone;
        end else begin
          layer_idx_d = layer_idx_q + LW'(1);
          state_d     = StCfg;
        end
      end

      StDone: begin
        abort_d = 1'b0;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      layer_idx_q <= '0;
      base_sel_q  <= 1'b0;
      abort_q     <= 1'b0;
      err_q       <= ErrOk;
      mode_q      <= 1'b0;
      stride_q    <= '0;
      in_h_q      <= '0;
      in_w_q      <= '0;
      in_c_q      <= '0;
      out_h_q     <= '0;
      out_w_q     <= '0;
      out_c_q     <= '0;
      row_q       <= '0;
      col_q       <= '0;
    end else begin
      state_q     <= state_d;
      layer_idx_q <= layer_idx_d;
      base_sel_q  <= base_sel_d;
      abort_q     <= abort_d;
      err_q       <= err_d;
      mode_q      <= mode_d;
      stride_q    <= stride_d;
      in_h_q      <= in_h_d;
      in_w_q      <= in_w_d;
      in_c_q      <= in_c_d;
      out_h_q     <= out_h_d;
      out_w_q     <= out_w_d;
      out_c_q     <= out_c_d;
      row_q       <= row_d;
      col_q       <= col_d;
    end
  end

  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign err        = err_q;
  assign run_start  = (state_q == StIssue) && !abort_pend;
  assign layer_idx  = layer_idx_q;
  assign run_mode   = mode_q;
  assign cur_in_h   = in_h_q;
  assign cur_in_w   = in_w_q;
  assign cur_in_c   = in_c_q;
  assign cur_out_h  = out_h_q;
  assign cur_out_w  = out_w_q;
  assign cur_out_c  = out_c_q;
  assign cur_stride = DIM_W'(stride_q);

  // Tile and address outputs are forced to zero while idle so that reset leaves
  // every output at 0; they only matter while a run is in progress.
  always_comb begin
    tile_out_row  = '0;
    tile_out_col  = '0;
    tile_out_h    = '0;
    tile_out_w    = '0;
    tile_in_row   = '0;
    tile_in_col   = '0;
    tile_in_h     = '0;
    tile_in_w     = '0;
    in_base_addr  = '0;
    out_base_addr = '0;
    if (busy) begin
      tile_out_row  = row_q;
      tile_out_col  = col_q;
      tile_out_h    = t_oh;
      tile_out_w    = t_ow;
      // Padding makes the first input row/col -1; the halo is left unclipped.
      tile_in_row   = (DIM_W+1)'(AW'(row_q) * AW'(stride_q) - AW'(1));
      tile_in_col   = (DIM_W+1)'(AW'(col_q) * AW'(stride_q) - AW'(1));
      tile_in_h     = DIM_W'((AW'(t_oh) - AW'(1)) * AW'(stride_q) + AW'(KERNEL));
      tile_in_w     = DIM_W'((AW'(t_ow) - AW'(1)) * AW'(stride_q) + AW'(KERNEL));
      in_base_addr  = base_sel_q ? cfg_fm_base1 : cfg_fm_base0;
      out_base_addr = base_sel_q ? cfg_fm_base0 : cfg_fm_base1;
    end
  end

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Self-checking bench for layer_seq_ctrl: table-driven single-layer runs checked
// against a tile scoreboard, plus hand-written multi-layer, abort, busy-write and
// reset sequences.
module tb_layer_seq_ctrl;

  localparam int LW = 5;
  localparam logic [31:0] B0 = 32'h1000_0000;
  localparam logic [31:0] B1 = 32'h2000_0000;

  logic clk = 1'b0;
  logic rst, start, abort, busy, done;
  logic [1:0] err;
  logic tbl_we, tbl_mode;
  logic [LW-1:0] tbl_waddr;
  logic [1:0] tbl_stride;
  logic [15:0] tbl_out_c;
  logic [LW:0] cfg_num_layers;
  logic [15:0] cfg_in_h, cfg_in_w, cfg_in_c;
  logic [31:0] cfg_fm_base0, cfg_fm_base1;
  logic [LW-1:0] layer_idx;
  logic run_mode;
  logic [15:0] cur_in_h, cur_in_w, cur_in_c, cur_out_h, cur_out_w, cur_out_c, cur_stride;
  logic [15:0] tile_out_row, tile_out_col, tile_out_h, tile_out_w, tile_in_h, tile_in_w;
  logic signed [16:0] tile_in_row, tile_in_col;
  logic [31:0] in_base_addr, out_base_addr;
  logic run_start, run_done;

  always #5 clk = ~clk;

  layer_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .err(err), .tbl_we(tbl_we), .tbl_waddr(tbl_waddr), .tbl_mode(tbl_mode),
    .tbl_stride(tbl_stride), .tbl_out_c(tbl_out_c), .cfg_num_layers(cfg_num_layers),
    .cfg_in_h(cfg_in_h), .cfg_in_w(cfg_in_w), .cfg_in_c(cfg_in_c),
    .cfg_fm_base0(cfg_fm_base0), .cfg_fm_base1(cfg_fm_base1), .layer_idx(layer_idx),
    .run_mode(run_mode), .cur_in_h(cur_in_h), .cur_in_w(cur_in_w), .cur_in_c(cur_in_c),
    .cur_out_h(cur_out_h), .cur_out_w(cur_out_w), .cur_out_c(cur_out_c),
    .cur_stride(cur_stride), .tile_out_row(tile_out_row), .tile_out_col(tile_out_col),
    .tile_out_h(tile_out_h), .tile_out_w(tile_out_w), .tile_in_row(tile_in_row),
    .tile_in_col(tile_in_col), .tile_in_h(tile_in_h), .tile_in_w(tile_in_w),
    .in_base_addr(in_base_addr), .out_base_addr(out_base_addr), .run_start(run_start),
    .run_done(run_done)
  );

  typedef struct packed {
    logic [15:0] row, col, oh, ow;
    logic [16:0] irow, icol;
    logic [15:0] ih, iw;
    logic [31:0] ibase, obase;
    logic        mode;
    logic [15:0] coh, cow, coc;
  } tile_t;

  typedef struct {
    logic        mode;
    logic [1:0]  stride;
    logic [15:0] outc, in_h, in_w;
    logic [1:0]  e_err;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int n_starts = 0;
  bit resp_en = 1'b1;
  tile_t exp_q[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic tile_t mk(int r, int c, int oh, int ow, int irow, int icol, int ih,
                               int iw, logic [31:0] ib, logic [31:0] ob, logic m,
                               int coh, int cow, int coc);
    tile_t t;
    t.row = 16'(r); t.col = 16'(c); t.oh = 16'(oh); t.ow = 16'(ow);
    t.irow = 17'(irow); t.icol = 17'(icol); t.ih = 16'(ih); t.iw = 16'(iw);
    t.ibase = ib; t.obase = ob; t.mode = m;
    t.coh = 16'(coh); t.cow = 16'(cow); t.coc = 16'(coc);
    return t;
  endfunction

  // Reference tiling of one layer, written with plain integer division.
  task automatic push_layer(int in_h, int in_w, int s, logic m, int coc,
                            logic [31:0] ib, logic [31:0] ob);
    int oh, ow, th, tw;
    oh = (in_h + s - 1) / s;
    ow = (in_w + s - 1) / s;
    for (int r = 0; r < oh; r += 16) begin
      for (int c = 0; c < ow; c += 16) begin
        th = (oh - r < 16) ? oh - r : 16;
        tw = (ow - c < 16) ? ow - c : 16;
        exp_q.push_back(mk(r, c, th, tw, r * s - 1, c * s - 1, (th - 1) * s + 3,
                           (tw - 1) * s + 3, ib, ob, m, oh, ow, coc));
      end
    end
  endtask

  // Scoreboard: every run_start must match the next expected tile.
  always @(negedge clk) begin
    if (run_start) begin
      tile_t a;
      tile_t e;
      n_starts++;
      a = {tile_out_row, tile_out_col, tile_out_h, tile_out_w, tile_in_row, tile_in_col,
           tile_in_h, tile_in_w, in_base_addr, out_base_addr, run_mode, cur_out_h,
           cur_out_w, cur_out_c};
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_run_start: got tile %0h expected none", a);
      end else begin
        e = exp_q.pop_front();
        check("tile", 256'(a), 256'(e));
      end
    end
  end

  // Auto responder: run_done three cycles after each run_start.
  initial begin
    run_done = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_en && run_start) begin
        repeat (3) @(posedge clk);
        #1 run_done = 1'b1;
        @(posedge clk);
        #1 run_done = 1'b0;
      end
    end
  end

  task automatic tbl_write(int a, logic m, logic [1:0] s, int oc);
    @(posedge clk);
    #1 tbl_we = 1'b1; tbl_waddr = LW'(a); tbl_mode = m; tbl_stride = s; tbl_out_c = 16'(oc);
    @(posedge clk);
    #1 tbl_we = 1'b0;
  endtask

  task automatic run_job(input string nm, input logic [1:0] e_err, output int lat);
    bit seen;
    seen = 1'b0;
    lat = 0;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        lat = i + 1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no done expected done", nm);
    end else begin
      check({nm, "_err"}, 256'(err), 256'(e_err));
      check({nm, "_drain"}, 256'(exp_q.size()), 256'(0));
      @(negedge clk);
      check({nm, "_done_pulse"}, 256'({done, busy}), 256'(0));
      check({nm, "_err_hold"}, 256'(err), 256'(e_err));
    end
  endtask

  task automatic wait_run_start(input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (run_start) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_no_run_start: got none expected run_start", nm);
    end
  endtask

  function automatic logic any_out();
    return |{busy, done, err, layer_idx, run_mode, cur_in_h, cur_in_w, cur_in_c, cur_out_h,
             cur_out_w, cur_out_c, cur_stride, tile_out_row, tile_out_col, tile_out_h,
             tile_out_w, tile_in_row, tile_in_col, tile_in_h, tile_in_w, in_base_addr,
             out_base_addr, run_start};
  endfunction

  vec_t vecs[7];

  initial begin
    int lat;
    int s0;
    vecs[0] = '{mode: 1'b1, stride: 2'd1, outc: 16'd64, in_h: 16'd20, in_w: 16'd20, e_err: 2'd0};
    vecs[1] = '{mode: 1'b0, stride: 2'd2, outc: 16'd32, in_h: 16'd33, in_w: 16'd17, e_err: 2'd0};
    vecs[2] = '{mode: 1'b0, stride: 2'd2, outc: 16'd8,  in_h: 16'd1,  in_w: 16'd1,  e_err: 2'd0};
    vecs[3] = '{mode: 1'b0, stride: 2'd3, outc: 16'd8,  in_h: 16'd8,  in_w: 16'd8,  e_err: 2'd1};
    vecs[4] = '{mode: 1'b1, stride: 2'd0, outc: 16'd8,  in_h: 16'd8,  in_w: 16'd8,  e_err: 2'd1};
    vecs[5] = '{mode: 1'b0, stride: 2'd1, outc: 16'd8,  in_h: 16'd0,  in_w: 16'd8,  e_err: 2'd3};
    vecs[6] = '{mode: 1'b1, stride: 2'd1, outc: 16'd7,  in_h: 16'd40, in_w: 16'd5,  e_err: 2'd0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; tbl_we = 1'b0; tbl_waddr = '0; tbl_mode = 1'b0;
    tbl_stride = '0; tbl_out_c = '0; cfg_num_layers = '0; cfg_in_h = '0; cfg_in_w = '0;
    cfg_in_c = '0; cfg_fm_base0 = B0; cfg_fm_base1 = B1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", 256'(any_out()), 256'(0));

    // Table-driven single-layer runs.
    foreach (vecs[k]) begin
      tbl_write(0, vecs[k].mode, vecs[k].stride, vecs[k].outc);
      cfg_num_layers = 6'd1; cfg_in_h = vecs[k].in_h; cfg_in_w = vecs[k].in_w; cfg_in_c = 16'd3;
      if (vecs[k].e_err == 2'd0)
        push_layer(int'(vecs[k].in_h), int'(vecs[k].in_w), int'(vecs[k].stride),
                   vecs[k].mode, int'(vecs[k].outc), B0, B1);
      s0 = n_starts;
      run_job($sformatf("vec%0d", k), vecs[k].e_err, lat);
      if (vecs[k].e_err == 2'd1) begin
        check("stride_err_latency", 256'(lat), 256'(2));
        check("stride_err_no_start", 256'(n_starts - s0), 256'(0));
      end
    end

    // Zero layer count.
    cfg_num_layers = '0;
    run_job("zero_layers", 2'd3, lat);

    // Two-layer network: conv s2 c32, then dws s1 c64, 32x32x3 input.
    tbl_write(0, 1'b0, 2'd2, 32);
    tbl_write(1, 1'b1, 2'd1, 64);
    cfg_num_layers = 6'd2; cfg_in_h = 16'd32; cfg_in_w = 16'd32; cfg_in_c = 16'd3;
    exp_q.push_back(mk(0, 0, 16, 16, -1, -1, 33, 33, B0, B1, 1'b0, 16, 16, 32));
    exp_q.push_back(mk(0, 0, 16, 16, -1, -1, 18, 18, B1, B0, 1'b1, 16, 16, 64));
    run_job("two_layer", 2'd0, lat);

    // 20x20 dws s1 with manual handshake: run_done in ISSUE must be ignored and a
    // table write while busy must not land.
    tbl_write(0, 1'b1, 2'd1, 64);
    cfg_num_layers = 6'd1; cfg_in_h = 16'd20; cfg_in_w = 16'd20;
    exp_q.push_back(mk(0, 0, 16, 16, -1, -1, 18, 18, B0, B1, 1'b1, 20, 20, 64));
    exp_q.push_back(mk(0, 16, 16, 4, -1, 15, 18, 6, B0, B1, 1'b1, 20, 20, 64));
    exp_q.push_back(mk(16, 0, 4, 16, 15, -1, 6, 18, B0, B1, 1'b1, 20, 20, 64));
    exp_q.push_back(mk(16, 16, 4, 4, 15, 15, 6, 6, B0, B1, 1'b1, 20, 20, 64));
    resp_en = 1'b0;
    fork
      run_job("manual_20x20", 2'd0, lat);
      begin
        for (int t = 0; t < 4; t++) begin
          wait_run_start("manual");
          run_done = 1'b1;
          if (t == 0) begin
            tbl_we = 1'b1; tbl_waddr = '0; tbl_mode = 1'b0; tbl_stride = 2'd2; tbl_out_c = 16'd99;
          end
          @(posedge clk);
          #1 run_done = 1'b0; tbl_we = 1'b0;
          repeat (2) @(posedge clk);
          #1 run_done = 1'b1;
          @(posedge clk);
          #1 run_done = 1'b0;
        end
      end
    join
    resp_en = 1'b1;
    push_layer(20, 20, 1, 1'b1, 64, B0, B1);
    run_job("table_kept", 2'd0, lat);

    // Abort while waiting on the first tile.
    exp_q.push_back(mk(0, 0, 16, 16, -1, -1, 18, 18, B0, B1, 1'b1, 20, 20, 64));
    s0 = n_starts;
    fork
      run_job("abort_wait", 2'd2, lat);
      begin
        wait_run_start("abort");
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    check("abort_starts", 256'(n_starts - s0), 256'(1));

    // Reset in the middle of WAIT.
    resp_en = 1'b0;
    exp_q.push_back(mk(0, 0, 16, 16, -1, -1, 18, 18, B0, B1, 1'b1, 20, 20, 64));
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_run_start("rst_mid");
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", 256'(busy), 256'(0));
    check("rst_mid_outputs", 256'(any_out()), 256'(0));
    s0 = n_starts;
    repeat (20) @(negedge clk);
    check("rst_mid_no_start", 256'(n_starts - s0), 256'(0));
    resp_en = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
